mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath: splits each instruction into fetch/decode/execute/memory/writeback steps and drives the datapath mux selects, write enables and ALU op.
- Shares one unified instruction/data memory port over a req/ready handshake.
- Sits between the instruction register opcode field and the datapath control inputs, replacing single-cycle control decode.
- Provides a run/halt gate at instruction boundaries and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
ILLEGAL_TRAP, 1, 1 = illegal opcode parks FSM in HALT; 0 = skip to next fetch

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
run  in  1  level; 1 = execute, 0 = stop at next instruction boundary
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU equality flag for beq (readA == readB)
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump address
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 funct-decoded
reg_write  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 r31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (for jal)
busy  out  1  1 whenever state != IDLE/HALT
illegal  out  1  one-cycle pulse on unsupported opcode
retired  out  CNT_W  count of completed instructions

Behaviour:
- State is registered; all control outputs are combinational decode of state, plus the mem_ready/zero qualifiers noted below. All unlisted outputs are 0 in every state.
- Reset (reset=0 at clk edge): state=IDLE, retired=0. All outputs are 0 in IDLE.
- IDLE: if run=1 go to FETCH, else stay.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
  - mem_req stays high continuously while waiting.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (precompute branch target). Next state by opcode:
  - 000000 → RTYPE
  - 100011 / 101011 → MEMADR
  - 000100 → BEQ
  - 001000 → ADDI
  - 000010 → JUMP
  - 000011 → JAL
  - other → illegal=1; HALT if ILLEGAL_TRAP else FETCH; retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. Instruction retires.
- MEMWR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready; the instruction retires on the mem_ready cycle.
- RTYPE: alu_src_a=1, alu_src_b=00, alu_op=010. Next is ALUWB.
- ALUWB: reg_write=1, reg_dst=01, mem_to_reg=00. Instruction retires.
- ADDI: alu_src_a=1, alu_src_b=10, alu_op=000. Next is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=00, mem_to_reg=00. Instruction retires.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_write=zero. Instruction retires.
- JUMP: pc_src=10, pc_write=1. Instruction retires.
- JAL: reg_write=1, reg_dst=10, mem_to_reg=10, pc_src=10, pc_write=1. Instruction retires.
  - PC still holds PC+4 in this cycle, so the link value is written before the PC update.
- Instruction boundary (after any retire state):
  - run=1 → FETCH.
  - run=0 → IDLE.
  - run is sampled only at boundaries; deasserting it mid-instruction never aborts the instruction.
- HALT: stays until reset. busy=0.
- retired:
  - Increments by 1 on each retiring cycle.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- Memory handshake:
  - mem_req, iord and mem_we must be stable every cycle until mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - Zero-wait memory (mem_ready tied 1) gives these cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3.
- Reset mid-instruction (including mid-wait with mem_req high): the next state is IDLE and mem_req drops the cycle after the reset edge. Partial register or PC writes are not rolled back.

Test Plan:
- reset=0 for 2 cycles, run=1, mem_ready=1, opcode=100011 → states IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 exactly in MEMWB; retired=1 after 6 cycles.
- sw (101011) with mem_ready held 0 for 3 cycles in MEMWR → mem_req=mem_we=iord=1 held for 4 cycles; retired increments only on the mem_ready cycle.
- beq (000100) with zero=1, then with zero=0 → pc_write=1 / 0 in the BEQ cycle; pc_src=01 in both cases.
- jal (000011) → JAL cycle shows reg_dst=10, mem_to_reg=10, pc_src=10, reg_write=1, pc_write=1 simultaneously.
- opcode=111111 with ILLEGAL_TRAP=1 → illegal pulses for 1 cycle, FSM stays in HALT with busy=0 despite run=1 until reset=0; with ILLEGAL_TRAP=0 it returns to FETCH and retired is unchanged.
- Drop run during an R-type EXEC → ALUWB completes and FSM enters IDLE. Preload CNT_W=4 with 15 retirements → 16th retirement wraps retired to 0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_control_fsm_if : unified instruction/data memory req/ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_control_fsm : multi-cycle MIPS control sequencer with run/halt gating
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               zero,
  mc_control_fsm_if.master   mem,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDI   = 4'd9,
    S_ADDIWB = 4'd10,
    S_BEQ    = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_HALT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  state_t boundary_next;
  logic   legal;
  logic   retire;

  always_comb begin
    legal  = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
    // run only matters at the instruction boundary that follows a retire state
    boundary_next = run ? S_FETCH : S_IDLE;
    retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB) ||
             (state == S_BEQ)   || (state == S_JUMP)  || (state == S_JAL)    ||
             ((state == S_MEMWR) && mem.mem_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + CNT_ONE;
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  if (mem.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= S_RTYPE;
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BEQ;
            OP_ADDI:      state <= S_ADDI;
            OP_J:         state <= S_JUMP;
            OP_JAL:       state <= S_JAL;
            default:      state <= ILLEGAL_TRAP ? S_HALT : S_FETCH;
          endcase
        end
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem.mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem.mem_ready) state <= boundary_next;
        S_RTYPE:  state <= S_ALUWB;
        S_ADDI:   state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP, S_JAL: state <= boundary_next;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    illegal     = 1'b0;
    busy        = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !legal;
      end
      S_MEMADR, S_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
      end
      S_RTYPE: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      // link value comes from the PC, which still holds PC+4 this cycle
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_src     = 2'b10;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_control_fsm : vector table, directed corners and random vs step model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       busy;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    ctl_t        exp;
    int unsigned ret;
  } vec_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_BAD = 6'b111111;

  localparam ctl_t E_IDLE    = '0;
  localparam ctl_t E_FETCH_R = '{mem_req: 1'b1, ir_write: 1'b1, pc_write: 1'b1, alu_src_b: 2'b01, busy: 1'b1, default: 0};
  localparam ctl_t E_FETCH_W = '{mem_req: 1'b1, alu_src_b: 2'b01, busy: 1'b1, default: 0};
  localparam ctl_t E_DECODE  = '{alu_src_b: 2'b11, busy: 1'b1, default: 0};
  localparam ctl_t E_MEMADR  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, busy: 1'b1, default: 0};
  localparam ctl_t E_MEMRD   = '{mem_req: 1'b1, iord: 1'b1, busy: 1'b1, default: 0};
  localparam ctl_t E_MEMWB   = '{reg_write: 1'b1, mem_to_reg: 2'b01, busy: 1'b1, default: 0};
  localparam ctl_t E_JAL     = '{reg_write: 1'b1, reg_dst: 2'b10, mem_to_reg: 2'b10, pc_src: 2'b10,
                                 pc_write: 1'b1, busy: 1'b1, default: 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       run_i [2];
  logic       zero_i[2];
  logic       rdy_i [2];
  logic [5:0] op_i  [2];

  mc_control_fsm_if m0();
  mc_control_fsm_if m1();
  assign m0.mem_ready = rdy_i[0];
  assign m1.mem_ready = rdy_i[1];

  logic       d0_ir_write, d0_pc_write, d0_alu_src_a, d0_reg_write, d0_busy, d0_illegal;
  logic [1:0] d0_pc_src, d0_alu_src_b, d0_reg_dst, d0_mem_to_reg;
  logic [2:0] d0_alu_op;
  logic [31:0] d0_retired;
  logic       d1_ir_write, d1_pc_write, d1_alu_src_a, d1_reg_write, d1_busy, d1_illegal;
  logic [1:0] d1_pc_src, d1_alu_src_b, d1_reg_dst, d1_mem_to_reg;
  logic [2:0] d1_alu_op;
  logic [3:0] d1_retired;

  mc_control_fsm #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .run(run_i[0]), .opcode(op_i[0]), .zero(zero_i[0]), .mem(m0),
    .ir_write(d0_ir_write), .pc_write(d0_pc_write), .pc_src(d0_pc_src), .alu_src_a(d0_alu_src_a),
    .alu_src_b(d0_alu_src_b), .alu_op(d0_alu_op), .reg_write(d0_reg_write), .reg_dst(d0_reg_dst),
    .mem_to_reg(d0_mem_to_reg), .busy(d0_busy), .illegal(d0_illegal), .retired(d0_retired));

  mc_control_fsm #(.CNT_W(4), .ILLEGAL_TRAP(1'b0)) dut1 (
    .clk(clk), .reset(rst_n[1]), .run(run_i[1]), .opcode(op_i[1]), .zero(zero_i[1]), .mem(m1),
    .ir_write(d1_ir_write), .pc_write(d1_pc_write), .pc_src(d1_pc_src), .alu_src_a(d1_alu_src_a),
    .alu_src_b(d1_alu_src_b), .alu_op(d1_alu_op), .reg_write(d1_reg_write), .reg_dst(d1_reg_dst),
    .mem_to_reg(d1_mem_to_reg), .busy(d1_busy), .illegal(d1_illegal), .retired(d1_retired));

  ctl_t            act    [2];
  longint unsigned act_ret[2];
  always_comb begin
    act[0] = {m0.mem_req, m0.mem_we, m0.iord, d0_ir_write, d0_pc_write, d0_pc_src, d0_alu_src_a,
              d0_alu_src_b, d0_alu_op, d0_reg_write, d0_reg_dst, d0_mem_to_reg, d0_busy, d0_illegal};
    act[1] = {m1.mem_req, m1.mem_we, m1.iord, d1_ir_write, d1_pc_write, d1_pc_src, d1_alu_src_a,
              d1_alu_src_b, d1_alu_op, d1_reg_write, d1_reg_dst, d1_mem_to_reg, d1_busy, d1_illegal};
    act_ret[0] = longint'(d0_retired);
    act_ret[1] = longint'(d1_retired);
  end

  // Reference: each instruction expands into a list of named micro-steps
  string           q     [2][$];
  bit              halted[2];
  bit              trap  [2];
  longint unsigned mret  [2];
  longint unsigned mmask [2];
  int              vectors = 0;
  int              miscompares = 0;
  bit              cmp_en = 1'b0;

  task automatic chk(string name, int d, longint unsigned a, longint unsigned e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, a, e);
    end
  endtask

  function automatic ctl_t model_out(int d);
    ctl_t e;
    e = '0;
    if (q[d].size() == 0) return e;
    e.busy = 1'b1;
    case (q[d][0])
      "F":   begin e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy_i[d]; e.pc_write = rdy_i[d]; end
      "D":   begin e.alu_src_b = 2'b11;
                   e.illegal = !(op_i[d] inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL}); end
      "MA":  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      "MR":  begin e.mem_req = 1'b1; e.iord = 1'b1; end
      "MWB": begin e.reg_write = 1'b1; e.mem_to_reg = 2'b01; end
      "MW":  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; end
      "R":   begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
      "AWB": begin e.reg_write = 1'b1; e.reg_dst = 2'b01; end
      "I":   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      "IWB": e.reg_write = 1'b1;
      "B":   begin e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_write = zero_i[d]; end
      "J":   begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      "JL":  begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
                   e.pc_src = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step(int d);
    string s;
    if (!rst_n[d]) begin q[d].delete(); halted[d] = 1'b0; mret[d] = 0; return; end
    if (halted[d]) return;
    if (q[d].size() == 0) begin
      if (run_i[d]) q[d].push_back("F");
      return;
    end
    s = q[d][0];
    if (s == "F") begin
      if (rdy_i[d]) begin s = q[d].pop_front(); q[d].push_back("D"); end
    end else if (s == "D") begin
      s = q[d].pop_front();
      case (op_i[d])
        OP_LW:   begin q[d].push_back("MA"); q[d].push_back("MR"); q[d].push_back("MWB"); end
        OP_SW:   begin q[d].push_back("MA"); q[d].push_back("MW"); end
        OP_R:    begin q[d].push_back("R");  q[d].push_back("AWB"); end
        OP_ADDI: begin q[d].push_back("I");  q[d].push_back("IWB"); end
        OP_BEQ:  q[d].push_back("B");
        OP_J:    q[d].push_back("J");
        OP_JAL:  q[d].push_back("JL");
        default: if (trap[d]) halted[d] = 1'b1; else q[d].push_back("F");
      endcase
    end else if ((s == "MR" || s == "MW") && !rdy_i[d]) begin
      // memory wait: hold
    end else begin
      s = q[d].pop_front();
      if (q[d].size() == 0) begin
        mret[d] = (mret[d] + 1) & mmask[d];
        if (run_i[d]) q[d].push_back("F");
      end
    end
  endtask

  task automatic tick();
    #1;
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("ctl", d, longint'(act[d]), longint'(model_out(d)));
        chk("retired", d, act_ret[d], mret[d]);
      end
    end
    for (int d = 0; d < 2; d++) model_step(d);
    @(negedge clk);
  endtask

  task automatic do_reset(int d);
    rst_n[d] = 1'b0;
    run_i[d] = 1'b0;
    tick();
    tick();
    rst_n[d] = 1'b1;
  endtask

  task automatic set_in(int d, logic run, logic [5:0] op, logic zero, logic rdy);
    run_i[d] = run; op_i[d] = op; zero_i[d] = zero; rdy_i[d] = rdy;
  endtask

  vec_t tbl[12];
  int   cnt;
  int   cnt1;

  initial begin
    logic [5:0] legal_ops[7];
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
    trap  = '{1'b1, 1'b0};
    mmask = '{64'hFFFF_FFFF, 64'hF};
    tbl[0]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_IDLE,    0};
    tbl[1]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_FETCH_R, 0};
    tbl[2]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_DECODE,  0};
    tbl[3]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_MEMADR,  0};
    tbl[4]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_MEMRD,   0};
    tbl[5]  = '{1'b1, 1'b1, OP_LW,  1'b0, 1'b1, E_MEMWB,   0};
    tbl[6]  = '{1'b1, 1'b1, OP_JAL, 1'b0, 1'b0, E_FETCH_W, 1};
    tbl[7]  = '{1'b1, 1'b1, OP_JAL, 1'b0, 1'b1, E_FETCH_R, 1};
    tbl[8]  = '{1'b1, 1'b1, OP_JAL, 1'b0, 1'b1, E_DECODE,  1};
    tbl[9]  = '{1'b1, 1'b0, OP_JAL, 1'b0, 1'b1, E_JAL,     1};
    tbl[10] = '{1'b1, 1'b0, OP_JAL, 1'b0, 1'b1, E_IDLE,    2};
    tbl[11] = '{1'b1, 1'b0, OP_JAL, 1'b0, 1'b1, E_IDLE,    2};

    for (int d = 0; d < 2; d++) begin
      set_in(d, 1'b0, OP_R, 1'b0, 1'b1);
      rst_n[d] = 1'b0;
    end
    tick();
    tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    cmp_en = 1'b1;

    // lw / jal walk through every step
    for (int i = 0; i < 12; i++) begin
      rst_n[0] = tbl[i].rst;
      set_in(0, tbl[i].run, tbl[i].op, tbl[i].zero, tbl[i].rdy);
      #1;
      chk("tbl_ctl", 0, longint'(act[0]), longint'(tbl[i].exp));
      chk("tbl_retired", 0, act_ret[0], longint'(tbl[i].ret));
      tick();
    end

    // sw with three wait states
    do_reset(0);
    set_in(0, 1'b1, OP_SW, 1'b0, 1'b1);
    repeat (4) tick();
    cnt = 0;
    rdy_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin rdy_i[0] = 1'b1; run_i[0] = 1'b0; end
      #1;
      if (m0.mem_req && m0.mem_we && m0.iord) cnt++;
      if (i == 3) chk("sw_ret_before", 0, act_ret[0], 0);
      tick();
    end
    chk("sw_req_cycles", 0, longint'(cnt), 4);
    chk("sw_ret_after", 0, act_ret[0], 1);

    // beq taken then not taken
    do_reset(0);
    set_in(0, 1'b1, OP_BEQ, 1'b1, 1'b1);
    repeat (3) tick();
    #1;
    chk("beq_z1_pcw_src", 0, longint'({d0_pc_write, d0_pc_src}), 3'b101);
    tick();
    zero_i[0] = 1'b0;
    repeat (2) tick();
    #1;
    chk("beq_z0_pcw_src", 0, longint'({d0_pc_write, d0_pc_src}), 3'b001);
    tick();

    // illegal opcode: trap on dut0, skip on dut1
    do_reset(0);
    do_reset(1);
    set_in(0, 1'b1, OP_BAD, 1'b0, 1'b1);
    set_in(1, 1'b1, OP_BAD, 1'b0, 1'b1);
    cnt = 0;
    cnt1 = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (d0_illegal) cnt++;
      if (d1_illegal) cnt1++;
      tick();
    end
    chk("trap_illegal_pulses", 0, longint'(cnt), 1);
    chk("trap_busy", 0, longint'(d0_busy), 0);
    chk("skip_illegal_pulses", 1, longint'(cnt1), 4);
    chk("skip_retired", 1, act_ret[1], 0);
    do_reset(0);
    run_i[1] = 1'b0;
    repeat (3) tick();

    // run dropped during R-type execute
    do_reset(0);
    set_in(0, 1'b1, OP_R, 1'b0, 1'b1);
    repeat (3) tick();
    run_i[0] = 1'b0;
    repeat (2) tick();
    #1;
    chk("rtype_stop_busy", 0, longint'(d0_busy), 0);
    chk("rtype_stop_ret", 0, act_ret[0], 1);

    // 4-bit counter wrap on dut1
    do_reset(1);
    set_in(1, 1'b1, OP_J, 1'b0, 1'b1);
    repeat (46) tick();
    #1;
    chk("wrap_15", 1, act_ret[1], 15);
    repeat (3) tick();
    #1;
    chk("wrap_0", 1, act_ret[1], 0);

    // randomized traffic against the step model
    for (int n = 0; n < 4000; n++) begin
      for (int d = 0; d < 2; d++) begin
        rst_n[d]  = ($urandom_range(0, 149) != 0);
        run_i[d]  = ($urandom_range(0, 7) != 0);
        rdy_i[d]  = 1'($urandom_range(0, 1));
        zero_i[d] = 1'($urandom_range(0, 1));
        if (q[d].size() == 0 || q[d][0] == "F") begin
          if ($urandom_range(0, 59) == 0) op_i[d] = 6'($urandom());
          else op_i[d] = legal_ops[$urandom_range(0, 6)];
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
